// File: rtl/seq_csa_multiplier_pkg.sv
// Shared constants and state encoding for the sequential carry-save multiplier.
package seq_csa_multiplier_pkg;
    localparam int W     = 13;
    localparam int ROW_W = 2 * W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/seq_csa_multiplier_csa_row.sv
// Bitwise 3:2 compressor row; carry is returned at the same bit position (unshifted).
module csa_row #(
    parameter int N = 14
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);
    for (genvar i = 0; i < N; i++) begin : g_fa
        fulladder u_fa (
            .a   (x[i]),
            .b   (y[i]),
            .cin (z[i]),
            .s   (sum[i]),
            .cout(carry[i])
        );
    end
endmodule

// File: rtl/seq_csa_multiplier.sv
// Sequential 13x13 shift-add multiplier retiring one multiplier bit per cycle;
// the product leaves as two carry-save rows for a downstream final adder.
module seq_csa_multiplier
    import seq_csa_multiplier_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] sum_row,
    output logic [ROW_W-1:0] carry_row
);
    state_t       state, state_nxt;
    logic [W-1:0] a_r, b_r, plo_r;
    logic [W:0]   s_r, c_r;
    logic [W:0]   pp, sn, k;
    logic [3:0]   cnt;
    logic         last;

    assign last = (cnt == 4'(W - 1));
    assign pp   = b_r[cnt] ? {1'b0, a_r} : '0;

    csa_row #(.N(W + 1)) u_row (
        .x    (s_r),
        .y    (c_r),
        .z    (pp),
        .sum  (sn),
        .carry(k)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Rows come straight from registers that are frozen in DONE, so they stay
    // stable under backpressure without an extra output stage.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sum_row   = '0;
        carry_row = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                sum_row   = {s_r, plo_r};
                carry_row = {c_r, {W{1'b0}}};
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            c_r   <= '0;
            plo_r <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        s_r   <= '0;
                        c_r   <= '0;
                        plo_r <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // sn[0] has final weight 2^cnt; the rest moves up one weight.
                    plo_r[cnt] <= sn[0];
                    s_r        <= sn >> 1;
                    c_r        <= k;
                    if (!last) cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_csa_multiplier.sv
// Directed and randomized checks of the carry-save multiplier rows and handshakes.
module tb_seq_csa_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] sum_row, carry_row;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ops  = 0;
    int n_xfer = 0;
    logic overlap = 1'b0;

    seq_csa_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_row  (sum_row),
        .carry_row(carry_row)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (in_ready && out_valid) overlap = 1'b1;
    always @(posedge clk) if (!rst && out_valid && out_ready) n_xfer++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    // One full operation; hold = cycles of out_ready=0 once rows are valid.
    task automatic do_op(input logic [12:0] a, input logic [12:0] b, input logic [26:0] exp,
                         input int hold, output logic [26:0] so, output logic [26:0] co);
        int lat;
        int guard;
        logic [27:0] fa;
        out_ready = (hold == 0);
        guard = 0;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, 13);
        fa = {1'b0, sum_row} + {1'b0, carry_row};
        chk("product", fa, {1'b0, exp});
        chk("fa_cout", fa[27], 0);
        chk("carry_lo_zero", carry_row[12:0], 0);
        chk("in_ready_done", in_ready, 0);
        so = sum_row;
        co = carry_row;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = 13'd5; in_b = 13'd5;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum_row, so);
            chk("hold_carry", carry_row, co);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_sum_zero", sum_row, 0);
        n_ops++;
    endtask

    initial begin
        logic [26:0] so, co;
        logic seen;
        logic [12:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum_row, 0);
        chk("rst_carry", carry_row, 0);

        do_op(13'd3, 13'd5, 27'd15, 0, so, co);
        do_op(13'h1FFF, 13'h1FFF, 27'h3FFC001, 0, so, co);
        do_op(13'h0, 13'h1ABC, 27'd0, 0, so, co);
        chk("zero_sum", so, 0);
        chk("zero_carry", co, 0);
        do_op(13'h1ABC, 13'h1, 27'h1ABC, 0, so, co);
        chk("ident_sum", so, 27'h1ABC);
        chk("ident_carry", co, 0);

        // backpressure, then confirm the operands offered in DONE were dropped
        do_op(13'd100, 13'd200, 27'd20000, 5, so, co);
        do_op(13'd2, 13'd3, 27'd6, 0, so, co);

        // reset in the middle of an operation
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 13'h1234; in_b = 13'h0567;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sum", sum_row, 0);
        chk("midrst_carry", carry_row, 0);
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; seen |= out_valid; end
        chk("midrst_no_output", seen, 0);
        do_op(13'd7, 13'd9, 27'd63, 0, so, co);

        for (int n = 0; n < 300; n++) begin
            ra = 13'($urandom_range(0, 8191));
            rb = 13'($urandom_range(0, 8191));
            do_op(ra, rb, 27'(ra) * 27'(rb), int'($urandom_range(0, 3)), so, co);
        end

        chk("xfer_count", n_xfer, n_ops);
        chk("no_ready_valid_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
